// File: rtl/blkgen_pkg.sv
// blkgen_pkg: op codes, FSM states and keyword constants for block_stream_gen
package blkgen_pkg;
  typedef enum logic [1:0] {OP_BEGIN = 2'd0, OP_END = 2'd1, OP_CHAR = 2'd2, OP_RSVD = 2'd3} op_t;
  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_KEY, S_TRAIL, S_LIT} state_t;
  localparam logic [2:0] KW_BEGIN_LEN = 3'd5;
  localparam logic [2:0] KW_END_LEN = 3'd3;
  localparam logic [7:0] ASCII_SP = 8'h20;
endpackage

// File: rtl/blkgen_kw_rom.sv
// blkgen_kw_rom: keyword byte lookup; BLKGEN_UPPER_EN selects uppercase letters
module blkgen_kw_rom (
  input  logic       is_end,
  input  logic [2:0] idx,
  output logic [7:0] kw_byte
);
`ifdef BLKGEN_UPPER_EN
  localparam logic [7:0] CASE_MASK = 8'hdf;
`else
  localparam logic [7:0] CASE_MASK = 8'hff;
`endif
  logic [7:0] lc;
  always_comb begin
    lc = 8'h00;
    case ({is_end, idx})
      4'b0_000: lc = "b";
      4'b0_001: lc = "e";
      4'b0_010: lc = "g";
      4'b0_011: lc = "i";
      4'b0_100: lc = "n";
      4'b1_000: lc = "e";
      4'b1_001: lc = "n";
      4'b1_010: lc = "d";
      default:  lc = 8'h00;
    endcase
  end
  // clearing bit 5 uppercases letters and leaves the zero filler untouched
  assign kw_byte = lc & CASE_MASK;
endmodule

// File: rtl/block_stream_gen.sv
// block_stream_gen: BEGIN/END/CHAR commands to a space-delimited ASCII byte stream with depth tracking; BLKGEN_UPPER_EN selects uppercase keywords
module block_stream_gen
  import blkgen_pkg::*;
#(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [7:0]         cmd_char,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_byte,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               err
);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  state_t state, state_n;
  logic [2:0] idx, idx_n, rom_idx;
  logic is_end, is_end_n, kw_last, err_n;
  logic [7:0] byte_n, kw_byte;
  logic [DEPTH_W-1:0] depth_n;
  // the ROM is addressed with the index of the byte loaded on the next advance
  assign rom_idx = (state == S_KEY) ? idx + 3'd1 : 3'd0;
  assign kw_last = idx == (is_end ? KW_END_LEN : KW_BEGIN_LEN) - 3'd1;
  blkgen_kw_rom u_rom (.is_end(is_end), .idx(rom_idx), .kw_byte(kw_byte));
  assign cmd_ready = state == S_IDLE;
  assign out_valid = state != S_IDLE;
  assign balanced = depth == '0 && !err;
  always_comb begin
    state_n = state;
    idx_n = idx;
    is_end_n = is_end;
    byte_n = out_byte;
    depth_n = depth;
    err_n = err;
    case (state)
      S_IDLE: if (cmd_valid) begin
        if (cmd_op == OP_BEGIN || cmd_op == OP_END) begin
          if (cmd_op == OP_BEGIN ? depth == DEPTH_MAX : depth == '0) err_n = 1'b1;
          else begin
            depth_n = cmd_op == OP_BEGIN ? depth + 1'b1 : depth - 1'b1;
            is_end_n = cmd_op == OP_END;
            byte_n = ASCII_SP;
            state_n = S_LEAD;
          end
        end else begin
          byte_n = cmd_char;
          state_n = S_LIT;
        end
      end
      S_LEAD: if (out_ready) begin
        idx_n = 3'd0;
        byte_n = kw_byte;
        state_n = S_KEY;
      end
      S_KEY: if (out_ready) begin
        idx_n = kw_last ? idx : idx + 3'd1;
        byte_n = kw_last ? ASCII_SP : kw_byte;
        state_n = kw_last ? S_TRAIL : S_KEY;
      end
      S_TRAIL, S_LIT: if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx <= 3'd0;
      is_end <= 1'b0;
      out_byte <= 8'h00;
      depth <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      is_end <= is_end_n;
      out_byte <= byte_n;
      depth <= depth_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_block_stream_gen.sv
// tb_block_stream_gen: directed scoreboard bench for block_stream_gen (DEPTH_W=2); honours BLKGEN_UPPER_EN
module tb_block_stream_gen;
  logic clk, reset, cmd_valid, cmd_ready, out_valid, out_ready, balanced, err;
  logic [1:0] cmd_op;
  logic [7:0] cmd_char, out_byte;
  logic [1:0] depth;
  int checks = 0, failures = 0, nbytes = 0, m_depth = 0, m_err = 0;
  logic [7:0] exp_q[$];
  logic toggle = 1'b0, stalled = 1'b0;
  logic [7:0] held = 8'h00;
`ifdef BLKGEN_UPPER_EN
  localparam string KW_B = " BEGIN ", KW_E = " END ";
`else
  localparam string KW_B = " begin ", KW_E = " end ";
`endif

  block_stream_gen #(.DEPTH_W(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_char(cmd_char), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .depth(depth), .balanced(balanced), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  always @(negedge clk) begin
    if (reset) stalled = 1'b0;
    else begin
      if (stalled) chk("hold", int'({out_valid, out_byte}), int'({1'b1, held}));
      if (out_valid && out_ready) begin
        nbytes++;
        if (exp_q.size() == 0) chk("extra_byte", int'(out_byte), -1);
        else chk("byte", int'(out_byte), int'(exp_q.pop_front()));
      end
      stalled = out_valid && !out_ready;
      held = out_byte;
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (toggle) out_ready = ~out_ready;
  end

  task automatic send(input logic [1:0] op, input logic [7:0] ch);
    int n;
    logic emit;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("cmd_ready_wait", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_char = ch;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    emit = 1'b1;
    if (op == 2'd0) begin
      if (m_depth == 3) begin m_err = 1; emit = 1'b0; end
      else begin m_depth++; push_str(KW_B); end
    end else if (op == 2'd1) begin
      if (m_depth == 0) begin m_err = 1; emit = 1'b0; end
      else begin m_depth--; push_str(KW_E); end
    end else exp_q.push_back(ch);
    chk("first_byte_valid", int'(out_valid), int'(emit));
    chk("cmd_ready_after", int'(cmd_ready), int'(!emit));
    chk("depth", int'(depth), m_depth);
    chk("err", int'(err), m_err);
    chk("balanced", int'(balanced), int'(m_depth == 0 && m_err == 0));
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    exp_q.delete();
    m_depth = 0;
    m_err = 0;
    @(posedge clk);
    #1;
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_depth", int'(depth), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_balanced", int'(balanced), 1);
    reset = 1'b0;
    nbytes = 0;
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_char = 8'h00;
    out_ready = 1'b1;
    #1;
    chk("rst_byte", int'(out_byte), 0);
    do_reset();
    send(2'd0, 8'h00);
    send(2'd1, 8'h00);
    drain();
    chk("t1_count", nbytes, 12);

    do_reset();
    send(2'd1, 8'h00);
    drain();
    chk("t2_count", nbytes, 0);

    do_reset();
    toggle = 1'b1;
    send(2'd0, 8'h00);
    drain();
    toggle = 1'b0;
    out_ready = 1'b1;
    chk("t3_count", nbytes, 7);

    do_reset();
    repeat (4) send(2'd0, 8'h00);
    drain();
    chk("t4_count", nbytes, 21);
    chk("t4_depth", int'(depth), 3);

    do_reset();
    send(2'd0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_valid", int'(out_valid), 0);
    chk("t5_depth", int'(depth), 0);
    chk("t5_ready", int'(cmd_ready), 1);
    exp_q.delete();
    m_depth = 0;
    m_err = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    nbytes = 0;
    send(2'd0, 8'h00);
    send(2'd2, "x");
    send(2'd3, "!");
    send(2'd1, 8'h00);
    drain();
    chk("t6_count", nbytes, 14);
    chk("t6_balanced", int'(balanced), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
